// File: rtl/mux_channel_scanner_if.sv
// Signal bundle between the channel scanner, the 16-to-1 mux it drives and the
// consumer of the packed scan word.
interface mux_channel_scanner_if #(
    parameter int NUM_CH = 16,
    parameter int SEL_W  = 4
);
    // Control and mux side
    logic              start;
    logic              abort;
    logic [NUM_CH-1:0] ch_mask;
    logic              mux_out;
    logic [SEL_W-1:0]  select_lines;
    logic              busy;

    // Result handshake: scan_word is held while valid=1 and is consumed at a
    // rising edge where valid=1 and ready=1; valid never drops before that edge.
    logic [NUM_CH-1:0] scan_word;
    logic              valid;
    logic              ready;

    // Scanner side
    modport slave (
        input  start, abort, ch_mask, mux_out, ready,
        output select_lines, busy, scan_word, valid
    );

    // Controller / consumer / mux-model side
    modport master (
        output start, abort, ch_mask, mux_out, ready,
        input  select_lines, busy, scan_word, valid
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Steps a 16-to-1 mux through every enabled channel, waits a settle time per
// channel, samples the mux output and hands the packed word downstream.
module mux_channel_scanner #(
    parameter int NUM_CH = 16,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_channel_scanner_if.slave bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

    state_t            state_q;
    logic [SEL_W-1:0]  ch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] shadow_q;
    logic [SEL_W-1:0]  sel_q;
    logic              busy_q;
    logic              valid_q;
    logic [NUM_CH-1:0] word_q;

    logic [NUM_CH-1:0] shadow_d;
    logic [SEL_W-1:0]  ch_d;
    logic              settle_done;
    logic              last_ch;

    // Shadow with the current channel's bit written: the sampled mux value in
    // SAMPLE, zero for a masked channel skipped in SETTLE.
    always_comb begin
        shadow_d          = shadow_q;
        shadow_d[ch_q]    = (state_q == S_SAMPLE) ? bus.mux_out : 1'b0;
        ch_d              = ch_q + SEL_W'(1);
        settle_done       = (SETTLE == 0) || (cnt_q == CNT_LAST);
        last_ch           = (ch_q == LAST_CH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            word_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mask_q   <= bus.ch_mask;
                        shadow_q <= '0;
                        ch_q     <= '0;
                        cnt_q    <= '0;
                        sel_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (bus.abort) begin
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (!mask_q[ch_q]) begin
                        // Masked channel: record a zero and move on without settling
                        shadow_q <= shadow_d;
                        cnt_q    <= '0;
                        if (last_ch) begin
                            word_q  <= shadow_d;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            ch_q  <= ch_d;
                            sel_q <= ch_d;
                        end
                    end else if (settle_done) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_SAMPLE: begin
                    if (bus.abort) begin
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        shadow_q <= shadow_d;
                        cnt_q    <= '0;
                        if (last_ch) begin
                            word_q  <= shadow_d;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            ch_q    <= ch_d;
                            sel_q   <= ch_d;
                            state_q <= S_SETTLE;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        sel_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.select_lines = sel_q;
    assign bus.busy         = busy_q;
    assign bus.valid        = valid_q;
    assign bus.scan_word    = word_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for the mux channel scanner: one SETTLE=1 and one SETTLE=0
// instance, each reading a behavioural 16-to-1 mux.
module tb_mux_channel_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mux_in0;
  logic [15:0] mux_in1;
  logic [1:0]  state0;
  logic [1:0]  state1;
  int          tests_run    = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  mux_channel_scanner_if #(.NUM_CH(16), .SEL_W(4)) bus0 ();
  mux_channel_scanner_if #(.NUM_CH(16), .SEL_W(4)) bus1 ();

  assign bus0.mux_out = mux_in0[bus0.select_lines];
  assign bus1.mux_out = mux_in1[bus1.select_lines];

  mux_channel_scanner #(.NUM_CH(16), .SEL_W(4), .SETTLE(0)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus0.slave),
    .dbg_state_o (state0)
  );

  mux_channel_scanner #(.NUM_CH(16), .SEL_W(4), .SETTLE(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus1.slave),
    .dbg_state_o (state1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start pulse on the SETTLE=1 instance; returns just after the accepting edge.
  task automatic start1(input logic [15:0] mask);
    bus1.ch_mask = mask;
    bus1.start   = 1'b1;
    step();
    bus1.start   = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus1.busy, bus1.valid, bus1.select_lines, state1} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctrl1: got busy=%b valid=%b sel=%0d st=%0d exp all 0",
               bus1.busy, bus1.valid, bus1.select_lines, state1);
    end
    tests_run++;
    if (bus1.scan_word !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_word1: got %h exp 0000", bus1.scan_word);
    end
    tests_run++;
    if ({bus0.busy, bus0.valid, bus0.select_lines, state0, bus0.scan_word} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_dut0: got busy=%b valid=%b sel=%0d st=%0d word=%h exp all 0",
               bus0.busy, bus0.valid, bus0.select_lines, state0, bus0.scan_word);
    end
  endtask

  task automatic test_full_scan();
    logic [4:0] exp;
    mux_in1    = 16'hA5C3;
    bus1.ready = 1'b1;
    start1(16'hFFFF);
    for (int j = 0; j < 32; j++) begin
      if (j > 0) step();
      exp = {1'b1, 4'(j / 2)};
      tests_run++;
      if ({bus1.busy, bus1.select_lines} !== exp || bus1.valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_scan_sel cyc %0d: got busy=%b sel=%0d valid=%b exp busy=1 sel=%0d valid=0",
                 j, bus1.busy, bus1.select_lines, bus1.valid, exp[3:0]);
      end
    end
    step();
    tests_run++;
    if (bus1.valid !== 1'b1 || bus1.scan_word !== 16'hA5C3 || bus1.busy !== 1'b0
        || bus1.select_lines !== 4'd15) begin
      tests_failed++;
      $display("FAIL full_scan_done: got valid=%b word=%h busy=%b sel=%0d exp 1 a5c3 0 15",
               bus1.valid, bus1.scan_word, bus1.busy, bus1.select_lines);
    end
    step();
    tests_run++;
    if (bus1.valid !== 1'b0 || state1 !== 2'd0 || bus1.scan_word !== 16'hA5C3) begin
      tests_failed++;
      $display("FAIL full_scan_handshake: got valid=%b st=%0d word=%h exp 0 0 a5c3",
               bus1.valid, state1, bus1.scan_word);
    end
  endtask

  task automatic test_masked_scan();
    logic [3:0] exp_sel;
    mux_in1    = 16'hFFFF;
    bus1.ready = 1'b1;
    start1(16'h00FF);
    for (int j = 0; j < 24; j++) begin
      if (j > 0) step();
      exp_sel = (j < 16) ? 4'(j / 2) : 4'(j - 8);
      tests_run++;
      if (bus1.select_lines !== exp_sel || bus1.valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL masked_sel cyc %0d: got sel=%0d valid=%b exp sel=%0d valid=0",
                 j, bus1.select_lines, bus1.valid, exp_sel);
      end
    end
    step();
    tests_run++;
    if (bus1.valid !== 1'b1 || bus1.scan_word !== 16'h00FF) begin
      tests_failed++;
      $display("FAIL masked_done: got valid=%b word=%h exp 1 00ff", bus1.valid, bus1.scan_word);
    end
    step();
  endtask

  task automatic test_backpressure();
    mux_in0      = 16'h1234;
    bus0.ready   = 1'b0;
    bus0.ch_mask = 16'hFFFF;
    bus0.start   = 1'b1;
    step();
    bus0.start   = 1'b0;
    repeat (31) step();
    tests_run++;
    if (bus0.valid !== 1'b0 || bus0.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_early: got valid=%b busy=%b at start+31 exp 0 1", bus0.valid, bus0.busy);
    end
    step();
    tests_run++;
    if (bus0.valid !== 1'b1 || bus0.scan_word !== 16'h1234) begin
      tests_failed++;
      $display("FAIL bp_done: got valid=%b word=%h at start+32 exp 1 1234", bus0.valid, bus0.scan_word);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bus0.ch_mask = 16'h0000;
        bus0.start   = 1'b1;
      end
      step();
      bus0.start = 1'b0;
      tests_run++;
      if (bus0.valid !== 1'b1 || bus0.scan_word !== 16'h1234 || state0 !== 2'd3) begin
        tests_failed++;
        $display("FAIL bp_hold cyc %0d: got valid=%b word=%h st=%0d exp 1 1234 3",
                 i, bus0.valid, bus0.scan_word, state0);
      end
    end
    bus0.ready = 1'b1;
    step();
    bus0.ready = 1'b0;
    tests_run++;
    if (bus0.valid !== 1'b0 || state0 !== 2'd0 || bus0.select_lines !== 4'd0) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b st=%0d sel=%0d exp 0 0 0",
               bus0.valid, state0, bus0.select_lines);
    end
    step();
    tests_run++;
    if (bus0.busy !== 1'b0 || state0 !== 2'd0) begin
      tests_failed++;
      $display("FAIL bp_no_queue: got busy=%b st=%0d exp 0 0", bus0.busy, state0);
    end
  endtask

  task automatic test_abort();
    mux_in1    = 16'h5555;
    bus1.ready = 1'b1;
    start1(16'hFFFF);
    repeat (32) step();
    tests_run++;
    if (bus1.valid !== 1'b1 || bus1.scan_word !== 16'h5555) begin
      tests_failed++;
      $display("FAIL abort_prior: got valid=%b word=%h exp 1 5555", bus1.valid, bus1.scan_word);
    end
    step();
    mux_in1 = 16'hFFFF;
    start1(16'hFFFF);
    repeat (14) step();
    tests_run++;
    if (bus1.select_lines !== 4'd7) begin
      tests_failed++;
      $display("FAIL abort_reach_ch7: got sel=%0d exp 7", bus1.select_lines);
    end
    bus1.abort = 1'b1;
    step();
    bus1.abort = 1'b0;
    tests_run++;
    if (bus1.busy !== 1'b0 || bus1.select_lines !== 4'd0 || bus1.valid !== 1'b0
        || bus1.scan_word !== 16'h5555 || state1 !== 2'd0) begin
      tests_failed++;
      $display("FAIL abort_effect: got busy=%b sel=%0d valid=%b word=%h st=%0d exp 0 0 0 5555 0",
               bus1.busy, bus1.select_lines, bus1.valid, bus1.scan_word, state1);
    end
    step();
    tests_run++;
    if (bus1.valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.scan_word !== 16'h5555) begin
      tests_failed++;
      $display("FAIL abort_after: got valid=%b busy=%b word=%h exp 0 0 5555",
               bus1.valid, bus1.busy, bus1.scan_word);
    end
  endtask

  task automatic test_async_reset();
    mux_in1    = 16'hFFFF;
    bus1.ready = 1'b1;
    start1(16'hFFFF);
    repeat (10) step();
    tests_run++;
    if (bus1.select_lines !== 4'd5) begin
      tests_failed++;
      $display("FAIL arst_reach_ch5: got sel=%0d exp 5", bus1.select_lines);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus1.busy, bus1.valid, bus1.select_lines, state1} !== 8'h00 || bus1.scan_word !== 16'h0000) begin
      tests_failed++;
      $display("FAIL arst_immediate: got busy=%b valid=%b sel=%0d st=%0d word=%h exp all 0",
               bus1.busy, bus1.valid, bus1.select_lines, state1, bus1.scan_word);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mux_in1 = 16'h3C96;
    start1(16'hFFFF);
    repeat (32) step();
    tests_run++;
    if (bus1.valid !== 1'b1 || bus1.scan_word !== 16'h3C96) begin
      tests_failed++;
      $display("FAIL arst_rescan: got valid=%b word=%h exp 1 3c96", bus1.valid, bus1.scan_word);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    mux_in1    = 16'hFFFF;
    bus1.ready = 1'b1;
    start1(16'h0F0F);
    repeat (6) step();
    tests_run++;
    if (bus1.select_lines !== 4'd3) begin
      tests_failed++;
      $display("FAIL swb_reach_ch3: got sel=%0d exp 3", bus1.select_lines);
    end
    bus1.ch_mask = 16'hFFFF;
    bus1.start   = 1'b1;
    step();
    bus1.start   = 1'b0;
    tests_run++;
    if (bus1.select_lines !== 4'd3 || bus1.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL swb_no_restart: got sel=%0d busy=%b exp 3 1", bus1.select_lines, bus1.busy);
    end
    repeat (16) step();
    tests_run++;
    if (bus1.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL swb_early: got valid=%b at start+23 exp 0", bus1.valid);
    end
    step();
    tests_run++;
    if (bus1.valid !== 1'b1 || bus1.scan_word !== 16'h0F0F) begin
      tests_failed++;
      $display("FAIL swb_done: got valid=%b word=%h at start+24 exp 1 0f0f", bus1.valid, bus1.scan_word);
    end
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    mux_in0      = '0;
    mux_in1      = '0;
    bus0.start   = 1'b0;
    bus0.abort   = 1'b0;
    bus0.ch_mask = '0;
    bus0.ready   = 1'b0;
    bus1.start   = 1'b0;
    bus1.abort   = 1'b0;
    bus1.ch_mask = '0;
    bus1.ready   = 1'b0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();

    test_full_scan();
    test_masked_scan();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_start_while_busy();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
